// File: rtl/init_array_s.sv
// Sequencer that fills the RC5 S array in external memory with S[i] = S[i-1] + qW (mod 2^w).
// Optional INIT_ARRAY_S_SEED_EN: generate the whole sequence internally from pW, ignoring S_sub_i.
module init_array_s #(
  parameter int             b        = 16,
  parameter int             b_length = 4,
  parameter int             w        = 32,
  parameter int             t        = 26,
  parameter int             t_length = 5,
  parameter logic [w-1:0]   qW       = 32'h9E3779B9
`ifdef INIT_ARRAY_S_SEED_EN
  ,
  parameter logic [w-1:0]   pW       = 32'hB7E15163
`endif
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic [w-1:0]        S_sub_i,
  output logic [t_length-1:0] S_address,
  output logic [w-1:0]        S_sub_i_prima,
  output logic                done
);

  // Key-length parameters only exist so this block drops into the key-schedule wrapper unchanged.
  localparam int unused_key_params = b + b_length;

  localparam logic [t_length-1:0] LAST_ADDR = t_length'(t - 1);
`ifdef INIT_ARRAY_S_SEED_EN
  localparam logic [t_length-1:0] FIRST_ADDR = '0;
`else
  localparam logic [t_length-1:0] FIRST_ADDR = t_length'(1);
`endif

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state;

`ifdef INIT_ARRAY_S_SEED_EN
  logic [w-1:0] acc;
  logic         unused_read_data;

  assign unused_read_data = ^S_sub_i;
`endif

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state     <= ST_START;
      S_address <= '0;
      done      <= 1'b0;
`ifdef INIT_ARRAY_S_SEED_EN
      acc       <= '0;
`endif
    end else begin
      case (state)
        ST_START: begin
          S_address <= FIRST_ADDR;
`ifdef INIT_ARRAY_S_SEED_EN
          acc       <= pW;
`endif
          state     <= ST_RUN;
        end
        ST_RUN: begin
`ifdef INIT_ARRAY_S_SEED_EN
          acc <= acc + qW;
`endif
          // The last word is written on this edge; the address then parks at t-1.
          if (S_address == LAST_ADDR) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            S_address <= S_address + 1'b1;
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          S_address <= LAST_ADDR;
        end
        default: begin
          state     <= ST_START;
          S_address <= '0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    S_sub_i_prima = '0;
    if (state == ST_RUN) begin
`ifdef INIT_ARRAY_S_SEED_EN
      S_sub_i_prima = acc;
`else
      S_sub_i_prima = S_sub_i + qW;
`endif
    end
  end

endmodule

// File: tb/tb_init_array_s.sv
// Bench for init_array_s: a word memory follows the read/write contract and the final
// array plus per-cycle outputs are compared against S[i] = S[0] + i*qW.
module tb_init_array_s;

  localparam int W  = 32;
  localparam int T  = 26;
  localparam int TL = 5;
  localparam logic [W-1:0] QW = 32'd5;
`ifdef INIT_ARRAY_S_SEED_EN
  localparam logic [W-1:0] PW = 32'd10;
  localparam int FIRST     = 0;
  localparam int DONE_LAT  = T + 1;
  localparam int N_WRITES  = T;
`else
  localparam int FIRST     = 1;
  localparam int DONE_LAT  = T;
  localparam int N_WRITES  = T - 1;
`endif
  localparam int HOLD   = 40;
  localparam int BUDGET = DONE_LAT + HOLD;

  logic          clk1 = 1'b0;
  logic          rst  = 1'b0;
  logic [W-1:0]  s_sub_i;
  logic [TL-1:0] s_address;
  logic [W-1:0]  s_sub_i_prima;
  logic          done;

  logic [W-1:0]  mem [0:31];
  logic [W-1:0]  s0_val = '0;
  int            edge_cnt = 0;
  int            write_cnt = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk1 = ~clk1;

  init_array_s #(
`ifdef INIT_ARRAY_S_SEED_EN
    .pW       (PW),
`endif
    .b        (16),
    .b_length (4),
    .w        (W),
    .t        (T),
    .t_length (TL),
    .qW       (QW)
  ) dut (
    .clk1          (clk1),
    .rst           (rst),
    .S_sub_i       (s_sub_i),
    .S_address     (s_address),
    .S_sub_i_prima (s_sub_i_prima),
    .done          (done)
  );

  // Memory side: combinational read of S[addr-1], write on the edge while running and not done.
`ifdef INIT_ARRAY_S_SEED_EN
  assign s_sub_i = '0;
`else
  assign s_sub_i = (s_address == '0) ? '0 : mem[s_address - 1'b1];
`endif

  always @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hDEADBEEF;
`ifndef INIT_ARRAY_S_SEED_EN
      mem[0] <= s0_val;
`endif
      edge_cnt  <= 0;
      write_cnt <= 0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (edge_cnt >= 1 && done == 1'b0) begin
        mem[s_address] <= s_sub_i_prima;
        write_cnt      <= write_cnt + 1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_addr"},  32'(s_address), 32'd0);
    check_output({tag, "_done"},  32'(done), 32'd0);
    check_output({tag, "_prima"}, s_sub_i_prima, 32'd0);
  endtask

  // One run from reset release; abort_addr >= 0 asserts rst mid-cycle once that address is active.
  task automatic apply_stimulus(input logic [W-1:0] s0, input int abort_addr);
    int           lat;
    int           exp_addr;
    logic [W-1:0] exp_s0;
    logic [W-1:0] exp_prima;
    logic         exp_done;
`ifdef INIT_ARRAY_S_SEED_EN
    exp_s0 = PW;
`else
    exp_s0 = s0;
`endif
    s0_val = s0;
    rst = 1'b1;
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    check_reset_values("start");
    lat = BUDGET + 1;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk1);
      if (n < DONE_LAT) begin
        exp_addr  = FIRST + n - 1;
        exp_prima = exp_s0 + 32'(exp_addr) * QW;
        exp_done  = 1'b0;
      end else begin
        exp_addr  = T - 1;
        exp_prima = '0;
        exp_done  = 1'b1;
      end
      check_output($sformatf("addr@%0d", n),  32'(s_address), 32'(exp_addr));
      check_output($sformatf("done@%0d", n),  32'(done), 32'(exp_done));
      check_output($sformatf("prima@%0d", n), s_sub_i_prima, exp_prima);
      if (done === 1'b1 && lat > BUDGET) lat = n;
      if (abort_addr >= 0 && n < DONE_LAT && exp_addr == abort_addr) begin
        #2 rst = 1'b1;
        #1 check_reset_values("midrun_reset");
        return;
      end
    end
    check_output("done_latency", 32'(lat), 32'(DONE_LAT));
    check_output("write_count", 32'(write_cnt), 32'(N_WRITES));
    for (int i = 0; i < T; i++)
      check_output($sformatf("mem[%0d]", i), mem[i], exp_s0 + 32'(i) * QW);
  endtask

  initial begin
    $display("[TB] init_array_s bench start");
    #2 rst = 1'b1;
    #1 check_reset_values("por");
    apply_stimulus(32'd10, -1);
    apply_stimulus(32'hFFFFFFFE, -1);
    apply_stimulus($urandom, 12);
    apply_stimulus($urandom, -1);
    apply_stimulus($urandom, 5);
    apply_stimulus($urandom, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
